// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute,
// memory and writeback, with memory timeout traps and a retired-instruction count.
module rv32_mc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_op,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] to_cnt;
  logic [1:0] cause_nxt;
  logic       retire;
  logic       legal;
  logic       waiting;
  logic       ready_seen;
  logic       timed_out;

  // funct3 is carried in the decoder interface but not needed for sequencing
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign waiting    = (state == S_FETCH) || (state == S_MEM);
  assign ready_seen = (state == S_FETCH) ? imem_ready : ((state == S_MEM) && dmem_ready);
  assign timed_out  = waiting && !ready_seen && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    cause_nxt = trap_cause;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_ready) begin
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd2;
        end
      end
      S_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd1;
        end else if (!legal) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd0;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_BRANCH, OP_FENCE: begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          OP_LOAD, OP_STORE: state_nxt = S_MEM;
          default:           state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timed_out) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd3;
        end
      end
      S_WB: begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Outputs are gated by rst_n so requests drop the moment reset asserts
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'b00;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    alu_op   = 2'b00;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          case (opcode)
            OP_BRANCH: begin
              alu_op = 2'b01;
              pc_we  = 1'b1;
              pc_src = {1'b0, branch_taken};
            end
            OP_FENCE:     pc_we  = 1'b1;
            OP_OP, OP_OPIMM: alu_op = 2'b10;
            default:      alu_op = 2'b00;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode == OP_STORE);
          pc_we    = dmem_ready && (opcode == OP_STORE);
        end
        S_WB: begin
          rf_we = (rd != 5'd0);
          pc_we = 1'b1;
          if (opcode == OP_LOAD) begin
            wb_sel = 2'b01;
          end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
            wb_sel = 2'b10;
          end
          if (opcode == OP_JAL) begin
            pc_src = 2'b01;
          end else if (opcode == OP_JALR) begin
            pc_src = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      to_cnt     <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || ready_seen) begin
        to_cnt <= '0;
      end else if (waiting) begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (retire) begin
        instret <= instret + 32'd1;
      end
      if (state_nxt == S_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= cause_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Testbench for rv32_mc_ctrl: each instruction is expanded into an expected
// per-cycle schedule from the sequencing rules, then driven and compared.
module tb_rv32_mc_ctrl;

  localparam int unsigned TO = 16;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, trap;
  logic [1:0]  pc_src, wb_sel, alu_op, trap_cause;
  logic [31:0] instret;

  rv32_mc_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .rd(rd),
    .branch_taken(branch_taken), .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        imr, dmr, bt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, trap;
    logic [1:0]  pc_src, wb_sel, alu_op, cause;
    logic [31:0] instret;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        c;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_instret = '0;
  logic        m_trap = 1'b0;
  logic [1:0]  m_cause = '0;
  int          n_run, n_ireq, n_dreq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Unrelated inputs are randomised every cycle to show they are ignored
  task automatic fresh();
    c.imr = 1'($urandom);
    c.dmr = 1'($urandom);
    c.bt  = 1'($urandom);
    c.op  = 7'($urandom);
    c.f3  = 3'($urandom);
    c.rd  = 5'($urandom);
    c.imem_req = 1'b0; c.dmem_req = 1'b0; c.dmem_we = 1'b0; c.ir_we = 1'b0;
    c.pc_we = 1'b0; c.rf_we = 1'b0;
    c.pc_src = 2'b00; c.wb_sel = 2'b00; c.alu_op = 2'b00;
    c.trap = m_trap; c.cause = m_cause; c.instret = m_instret;
  endtask

  task automatic set_ins(input logic [31:0] w);
    c.op = w[6:0];
    c.f3 = w[14:12];
    c.rd = w[11:7];
  endtask

  task automatic trap_tail(input logic [1:0] cause);
    m_trap  = 1'b1;
    m_cause = cause;
    repeat (4) begin
      fresh();
      q.push_back(c);
    end
  endtask

  task automatic build(input logic [31:0] w, input int fw, input int mw, input logic bt);
    logic [6:0] op;
    logic       lg;
    op = w[6:0];
    lg = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                    OP_STORE, OP_OPIMM, OP_OP, OP_FENCE};
    for (int i = 0; i < fw && i < int'(TO); i++) begin
      fresh(); c.imr = 1'b0; c.imem_req = 1'b1; q.push_back(c);
    end
    if (fw >= int'(TO)) begin trap_tail(2'd2); return; end
    fresh(); c.imr = 1'b1; c.imem_req = 1'b1; c.ir_we = 1'b1; q.push_back(c);
    fresh(); set_ins(w); q.push_back(c);
    if (op == OP_SYSTEM) begin trap_tail(2'd1); return; end
    if (!lg) begin trap_tail(2'd0); return; end
    fresh(); set_ins(w); c.bt = bt;
    if (op == OP_BRANCH || op == OP_FENCE) begin
      c.pc_we  = 1'b1;
      c.alu_op = (op == OP_BRANCH) ? 2'b01 : 2'b00;
      c.pc_src = (op == OP_BRANCH && bt) ? 2'b01 : 2'b00;
      q.push_back(c);
      m_instret++;
      return;
    end
    c.alu_op = (op == OP_OP || op == OP_OPIMM) ? 2'b10 : 2'b00;
    q.push_back(c);
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int i = 0; i < mw && i < int'(TO); i++) begin
        fresh(); set_ins(w); c.dmr = 1'b0; c.dmem_req = 1'b1;
        c.dmem_we = (op == OP_STORE); q.push_back(c);
      end
      if (mw >= int'(TO)) begin trap_tail(2'd3); return; end
      fresh(); set_ins(w); c.dmr = 1'b1; c.dmem_req = 1'b1; c.dmem_we = (op == OP_STORE);
      if (op == OP_STORE) begin
        c.pc_we = 1'b1;
        q.push_back(c);
        m_instret++;
        return;
      end
      q.push_back(c);
    end
    fresh(); set_ins(w);
    c.rf_we  = (w[11:7] != 5'd0);
    c.wb_sel = (op == OP_LOAD) ? 2'b01 : ((op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00);
    c.pc_we  = 1'b1;
    c.pc_src = (op == OP_JAL) ? 2'b01 : ((op == OP_JALR) ? 2'b10 : 2'b00);
    q.push_back(c);
    m_instret++;
  endtask

  task automatic run_q(input int max_cyc);
    cyc_t e;
    int   k;
    k = 0; n_run = 0; n_ireq = 0; n_dreq = 0;
    while (q.size() > 0 && k < max_cyc) begin
      e = q.pop_front();
      @(negedge clk);
      imem_ready = e.imr; dmem_ready = e.dmr; branch_taken = e.bt;
      opcode = e.op; funct3 = e.f3; rd = e.rd;
      #1;
      chk("imem_req",   32'(imem_req),   32'(e.imem_req));
      chk("dmem_req",   32'(dmem_req),   32'(e.dmem_req));
      chk("dmem_we",    32'(dmem_we),    32'(e.dmem_we));
      chk("ir_we",      32'(ir_we),      32'(e.ir_we));
      chk("pc_we",      32'(pc_we),      32'(e.pc_we));
      chk("pc_src",     32'(pc_src),     32'(e.pc_src));
      chk("rf_we",      32'(rf_we),      32'(e.rf_we));
      chk("wb_sel",     32'(wb_sel),     32'(e.wb_sel));
      chk("alu_op",     32'(alu_op),     32'(e.alu_op));
      chk("trap",       32'(trap),       32'(e.trap));
      chk("trap_cause", 32'(trap_cause), 32'(e.cause));
      chk("instret",    instret,         e.instret);
      if (!trap)    n_run++;
      if (imem_req) n_ireq++;
      if (dmem_req) n_dreq++;
      k++;
    end
  endtask

  task automatic model_reset();
    m_instret = '0; m_trap = 1'b0; m_cause = '0;
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1; opcode = OP_STORE;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_ir_we",    32'(ir_we),    32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_pc_we",    32'(pc_we),    32'd0);
    chk("rst_trap",     32'(trap),     32'd0);
    chk("rst_cause",    32'(trap_cause), 32'd0);
    chk("rst_instret",  instret,       32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    #1 chk("imem_req_after_release", 32'(imem_req), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  op;
    logic [6:0]  legal_ops [10];
    int          fw, mw;
    legal_ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                  OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_FENCE};

    do_reset();

    build(32'h00500093, 0, 0, 1'b0); run_q(100);          // ADDI x1,x0,5
    chk("addi_cycles", 32'(n_run), 32'd4);
    chk("addi_model_instret", m_instret, 32'd1);
    build(32'h0000A103, 0, 3, 1'b0); run_q(100);          // LW, 3 wait cycles
    chk("lw_cycles", 32'(n_run), 32'd8);
    chk("lw_dmem_req_cycles", 32'(n_dreq), 32'd4);
    build(32'h0020A023, 0, 0, 1'b0); run_q(100);          // SW
    chk("sw_cycles", 32'(n_run), 32'd4);
    build(32'h00000463, 0, 0, 1'b1); run_q(100);          // BEQ taken
    chk("beq_t_cycles", 32'(n_run), 32'd3);
    build(32'h00000463, 0, 0, 1'b0); run_q(100);          // BEQ not taken
    chk("beq_nt_cycles", 32'(n_run), 32'd3);
    build(32'h0000006F, 0, 0, 1'b0); run_q(100);          // JAL x0
    build(32'h000080E7, 0, 0, 1'b0); run_q(100);          // JALR x1
    chk("jalr_cycles", 32'(n_run), 32'd4);
    chk("seq_model_instret", m_instret, 32'd7);

    // Reset asserted between clock edges while a load waits in MEM
    build(32'h0000A103, 0, 10, 1'b0); run_q(5);
    #1 rst_n = 1'b0;
    #1;
    chk("midmem_dmem_req", 32'(dmem_req), 32'd0);
    chk("midmem_imem_req", 32'(imem_req), 32'd0);
    chk("midmem_instret",  instret,       32'd0);
    chk("midmem_trap",     32'(trap),     32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    #1 chk("midmem_imem_req_release", 32'(imem_req), 32'd1);

    build(32'h00500093, 0, 0, 1'b0); run_q(100);
    build(32'h0000007F, 0, 0, 1'b0); run_q(100);          // illegal opcode 0x7F
    chk("illegal_trap",    32'(trap),       32'd1);
    chk("illegal_cause",   32'(trap_cause), 32'd0);
    chk("illegal_instret", instret,         32'd1);
    chk("illegal_imem_req", 32'(imem_req),  32'd0);
    do_reset();
    build(32'h00000073, 0, 0, 1'b0); run_q(100);          // ECALL
    chk("ecall_trap",  32'(trap),       32'd1);
    chk("ecall_cause", 32'(trap_cause), 32'd1);
    do_reset();
    build(32'h00500093, 20, 0, 1'b0); run_q(100);         // fetch never ready
    chk("itimeout_fetch_cycles", 32'(n_ireq), 32'd16);
    chk("itimeout_cause", 32'(trap_cause), 32'd2);
    do_reset();
    build(32'h0000A103, 0, 20, 1'b0); run_q(100);         // load never ready
    chk("dtimeout_mem_cycles", 32'(n_dreq), 32'd16);
    chk("dtimeout_cause", 32'(trap_cause), 32'd3);
    do_reset();
    build(32'h00500093, 15, 0, 1'b0); run_q(100);         // ready on the last allowed cycle
    chk("fetch_edge_cycles", 32'(n_run), 32'd19);
    build(32'h0020A023, 10, 15, 1'b0); run_q(100);
    chk("mem_edge_cycles", 32'(n_run), 32'd29);
    chk("edge_model_instret", m_instret, 32'd2);

    for (int n = 0; n < 300; n++) begin
      op = legal_ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 99))
        0, 1, 2: op = OP_SYSTEM;
        3, 4, 5: begin
          do op = 7'($urandom);
          while (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                            OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM});
        end
        default: ;
      endcase
      fw = ($urandom_range(0, 24) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 24) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      w = $urandom;
      w[6:0] = op;
      build(w, fw, mw, 1'($urandom));
      run_q(1000);
      if (m_trap) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
